// File: rtl/fetch_unit_if.sv
// Instruction-fetch bus bundle: imem request/response, decode handshake and redirect inputs.
// master = fetch_unit side, slave = memory/decode/execute side.
interface fetch_unit_if;
    logic        io_imemReqValid;
    logic        io_imemReqReady;
    logic [31:0] io_imemAddr;
    logic        io_imemRspValid;
    logic [31:0] io_imemRspData;
    logic        io_instValid;
    logic        io_instReady;
    logic [31:0] io_inst;
    logic [4:0]  io_opcode;
    logic [31:0] io_pc;
    logic        io_redirect;
    logic [1:0]  io_nextPCsel;
    logic        io_branchTaken;
    logic [31:0] io_target;
    logic        io_misaligned;

    modport master (
        output io_imemReqValid, io_imemAddr, io_instValid, io_inst, io_opcode, io_pc, io_misaligned,
        input  io_imemReqReady, io_imemRspValid, io_imemRspData, io_instReady,
        input  io_redirect, io_nextPCsel, io_branchTaken, io_target
    );

    modport slave (
        input  io_imemReqValid, io_imemAddr, io_instValid, io_inst, io_opcode, io_pc, io_misaligned,
        output io_imemReqReady, io_imemRspValid, io_imemRspData, io_instReady,
        output io_redirect, io_nextPCsel, io_branchTaken, io_target
    );
endinterface

// File: rtl/fetch_unit.sv
// RV32I fetch front end: PC, single outstanding imem request, one-entry instruction buffer.
// Define FETCH_MISALIGN_CHECK_EN to flag (and halt on) misaligned redirect targets.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic          clock,
    input logic          reset,
    fetch_unit_if.master bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] HOLD = 2'd3;

    logic [1:0]  state, state_next;
    logic [31:0] pc, pc_next;
    logic        drop, drop_next;
    logic        capture;
    logic [31:0] addr_q, inst_q, inst_pc_q;
    logic        redirect_taken;
    logic [31:0] raw_target, target_eff;
    logic        misalign_hit;
    logic        halted;

    always_comb begin
        redirect_taken = bus.io_redirect &&
                         (bus.io_nextPCsel[1] || (bus.io_nextPCsel == 2'b01 && bus.io_branchTaken));
        raw_target = (bus.io_nextPCsel == 2'b11) ? {bus.io_target[31:1], 1'b0} : bus.io_target;
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misaligned_q;

    assign target_eff    = raw_target;
    assign misalign_hit  = redirect_taken && (raw_target[1:0] != 2'b00);
    assign halted        = misaligned_q;
    assign bus.io_misaligned = misaligned_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) misaligned_q <= 1'b0;
        else        misaligned_q <= misaligned_q | misalign_hit;
    end
`else
    assign target_eff    = raw_target & 32'hFFFF_FFFC;
    assign misalign_hit  = 1'b0;
    assign halted        = 1'b0;
    assign bus.io_misaligned = 1'b0;
`endif

    always_comb begin
        state_next = state;
        pc_next    = pc;
        drop_next  = drop;
        capture    = 1'b0;

        case (state)
            IDLE: if (!halted) state_next = REQ;
            REQ:  if (bus.io_imemReqReady) state_next = WAIT;
            WAIT: begin
                if (bus.io_imemRspValid) begin
                    if (drop || redirect_taken) begin
                        state_next = REQ;
                        drop_next  = 1'b0;
                    end else begin
                        capture    = 1'b1;
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (bus.io_instReady) begin
                    pc_next    = pc + 32'd4;
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase

        // Redirect overrides sequential PC; a request already on the bus must still
        // complete, so its response is marked stale rather than withdrawn.
        if (redirect_taken) begin
            pc_next = target_eff;
            case (state)
                REQ:     drop_next = 1'b1;
                WAIT:    if (!bus.io_imemRspValid) drop_next = 1'b1;
                HOLD:    state_next = REQ;
                default: ;
            endcase
            if (misalign_hit) begin
                state_next = IDLE;
                drop_next  = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            drop      <= 1'b0;
            addr_q    <= '0;
            inst_q    <= '0;
            inst_pc_q <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            drop  <= drop_next;
            if (state_next == REQ && state != REQ) addr_q <= pc_next;
            if (capture) begin
                inst_q    <= bus.io_imemRspData;
                inst_pc_q <= pc;
            end
        end
    end

    assign bus.io_imemReqValid = (state == REQ);
    assign bus.io_imemAddr     = addr_q;
    assign bus.io_instValid    = (state == HOLD);
    assign bus.io_inst         = inst_q;
    assign bus.io_opcode       = inst_q[6:2];
    assign bus.io_pc           = inst_pc_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (RESET_PC = 0x100).
module tb_fetch_unit;
    logic clock;
    logic reset;
    int unsigned passed;
    int unsigned total;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic accept();
        bus.io_imemReqReady = 1'b1;
        step();
        bus.io_imemReqReady = 1'b0;
    endtask

    task automatic respond(input logic [31:0] data);
        bus.io_imemRspValid = 1'b1;
        bus.io_imemRspData  = data;
        step();
        bus.io_imemRspValid = 1'b0;
    endtask

    task automatic set_redirect(input logic en, input logic [1:0] sel, input logic taken,
                                input logic [31:0] tgt);
        bus.io_redirect    = en;
        bus.io_nextPCsel   = sel;
        bus.io_branchTaken = taken;
        bus.io_target      = tgt;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        step();
        total++;
        if ({bus.io_imemReqValid, bus.io_instValid, bus.io_misaligned} !== 3'b000)
            $display("FAIL reset_flags: got %b expected 000",
                     {bus.io_imemReqValid, bus.io_instValid, bus.io_misaligned});
        else passed++;
        total++;
        if ({bus.io_imemAddr, bus.io_inst, bus.io_pc} !== 96'h0)
            $display("FAIL reset_data: got %h expected 0", {bus.io_imemAddr, bus.io_inst, bus.io_pc});
        else passed++;
        reset = 1'b1;
        #1;
        total++;
        if (bus.io_imemReqValid !== 1'b0)
            $display("FAIL idle_after_release: got %b expected 0", bus.io_imemReqValid);
        else passed++;
        step();
        total++;
        if ({bus.io_imemReqValid, bus.io_imemAddr} !== {1'b1, 32'h100})
            $display("FAIL first_req: got %h expected %h", {bus.io_imemReqValid, bus.io_imemAddr},
                     {1'b1, 32'h100});
        else passed++;
    endtask

    task automatic test_first_fetch();
        accept();
        total++;
        if (bus.io_imemReqValid !== 1'b0)
            $display("FAIL wait_no_req: got %b expected 0", bus.io_imemReqValid);
        else passed++;
        respond(32'h0000_0013);
        total++;
        if ({bus.io_instValid, bus.io_opcode, bus.io_pc, bus.io_inst} !==
            {1'b1, 5'b00100, 32'h100, 32'h13})
            $display("FAIL first_inst: got %h expected %h",
                     {bus.io_instValid, bus.io_opcode, bus.io_pc, bus.io_inst},
                     {1'b1, 5'b00100, 32'h100, 32'h13});
        else passed++;
    endtask

    task automatic test_hold_stall();
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if ({bus.io_instValid, bus.io_imemReqValid, bus.io_inst, bus.io_pc} !==
                {1'b1, 1'b0, 32'h13, 32'h100})
                $display("FAIL hold_stable[%0d]: got %h expected %h", i,
                         {bus.io_instValid, bus.io_imemReqValid, bus.io_inst, bus.io_pc},
                         {1'b1, 1'b0, 32'h13, 32'h100});
            else passed++;
        end
        bus.io_instReady = 1'b1;
        step();
        bus.io_instReady = 1'b0;
        total++;
        if ({bus.io_instValid, bus.io_imemReqValid, bus.io_imemAddr} !== {1'b0, 1'b1, 32'h104})
            $display("FAIL next_seq_req: got %h expected %h",
                     {bus.io_instValid, bus.io_imemReqValid, bus.io_imemAddr}, {1'b0, 1'b1, 32'h104});
        else passed++;
    endtask

    task automatic test_req_stall();
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if ({bus.io_imemReqValid, bus.io_imemAddr} !== {1'b1, 32'h104})
                $display("FAIL req_hold[%0d]: got %h expected %h", i,
                         {bus.io_imemReqValid, bus.io_imemAddr}, {1'b1, 32'h104});
            else passed++;
        end
        accept();
        respond(32'h0040_0093);
        total++;
        if ({bus.io_pc, bus.io_inst, bus.io_opcode} !== {32'h104, 32'h0040_0093, 5'b00100})
            $display("FAIL second_inst: got %h expected %h", {bus.io_pc, bus.io_inst, bus.io_opcode},
                     {32'h104, 32'h0040_0093, 5'b00100});
        else passed++;
        bus.io_instReady = 1'b1;
        step();
        bus.io_instReady = 1'b0;
        total++;
        if (bus.io_imemAddr !== 32'h108)
            $display("FAIL third_addr: got %h expected %h", bus.io_imemAddr, 32'h108);
        else passed++;
    endtask

    task automatic test_redirect_wait();
        accept();
        set_redirect(1'b1, 2'b10, 1'b0, 32'h200);
        step();
        set_redirect(1'b0, 2'b00, 1'b0, 32'h0);
        respond(32'h0000_006F);
        total++;
        if ({bus.io_instValid, bus.io_imemReqValid, bus.io_imemAddr} !== {1'b0, 1'b1, 32'h200})
            $display("FAIL jal_in_wait: got %h expected %h",
                     {bus.io_instValid, bus.io_imemReqValid, bus.io_imemAddr}, {1'b0, 1'b1, 32'h200});
        else passed++;
    endtask

    task automatic test_no_redirect();
        accept();
        respond(32'h0000_0063);
        total++;
        if (bus.io_pc !== 32'h200)
            $display("FAIL target_inst_pc: got %h expected %h", bus.io_pc, 32'h200);
        else passed++;
        set_redirect(1'b1, 2'b01, 1'b0, 32'h400);
        bus.io_instReady = 1'b1;
        step();
        bus.io_instReady = 1'b0;
        set_redirect(1'b0, 2'b00, 1'b0, 32'h0);
        total++;
        if (bus.io_imemAddr !== 32'h204)
            $display("FAIL branch_not_taken: got %h expected %h", bus.io_imemAddr, 32'h204);
        else passed++;
        accept();
        respond(32'h0000_0013);
        set_redirect(1'b1, 2'b00, 1'b1, 32'h500);
        bus.io_instReady = 1'b1;
        step();
        bus.io_instReady = 1'b0;
        set_redirect(1'b0, 2'b00, 1'b0, 32'h0);
        total++;
        if (bus.io_imemAddr !== 32'h208)
            $display("FAIL sel00_ignored: got %h expected %h", bus.io_imemAddr, 32'h208);
        else passed++;
    endtask

    task automatic test_jalr_hold();
        accept();
        respond(32'h0000_0067);
        set_redirect(1'b1, 2'b11, 1'b0, 32'h301);
        bus.io_instReady = 1'b1;
        step();
        bus.io_instReady = 1'b0;
        set_redirect(1'b0, 2'b00, 1'b0, 32'h0);
        total++;
        if ({bus.io_instValid, bus.io_imemReqValid, bus.io_imemAddr} !== {1'b0, 1'b1, 32'h300})
            $display("FAIL jalr_with_ready: got %h expected %h",
                     {bus.io_instValid, bus.io_imemReqValid, bus.io_imemAddr}, {1'b0, 1'b1, 32'h300});
        else passed++;
        accept();
        respond(32'h0000_0013);
        set_redirect(1'b1, 2'b10, 1'b0, 32'h400);
        step();
        set_redirect(1'b0, 2'b00, 1'b0, 32'h0);
        total++;
        if ({bus.io_instValid, bus.io_imemReqValid, bus.io_imemAddr} !== {1'b0, 1'b1, 32'h400})
            $display("FAIL jal_in_hold: got %h expected %h",
                     {bus.io_instValid, bus.io_imemReqValid, bus.io_imemAddr}, {1'b0, 1'b1, 32'h400});
        else passed++;
    endtask

    task automatic test_redirect_req();
        set_redirect(1'b1, 2'b10, 1'b0, 32'h500);
        step();
        set_redirect(1'b0, 2'b00, 1'b0, 32'h0);
        total++;
        if ({bus.io_imemReqValid, bus.io_imemAddr} !== {1'b1, 32'h400})
            $display("FAIL req_keeps_old_addr: got %h expected %h",
                     {bus.io_imemReqValid, bus.io_imemAddr}, {1'b1, 32'h400});
        else passed++;
        accept();
        respond(32'h0000_0013);
        total++;
        if ({bus.io_instValid, bus.io_imemReqValid, bus.io_imemAddr} !== {1'b0, 1'b1, 32'h500})
            $display("FAIL req_redirect_drop: got %h expected %h",
                     {bus.io_instValid, bus.io_imemReqValid, bus.io_imemAddr}, {1'b0, 1'b1, 32'h500});
        else passed++;
        accept();
        set_redirect(1'b1, 2'b01, 1'b1, 32'h600);
        respond(32'h0000_0013);
        set_redirect(1'b0, 2'b00, 1'b0, 32'h0);
        total++;
        if ({bus.io_instValid, bus.io_imemReqValid, bus.io_imemAddr} !== {1'b0, 1'b1, 32'h600})
            $display("FAIL rsp_redirect_same: got %h expected %h",
                     {bus.io_instValid, bus.io_imemReqValid, bus.io_imemAddr}, {1'b0, 1'b1, 32'h600});
        else passed++;
    endtask

    task automatic test_wrap();
        accept();
        set_redirect(1'b1, 2'b10, 1'b0, 32'hFFFF_FFFC);
        step();
        set_redirect(1'b0, 2'b00, 1'b0, 32'h0);
        respond(32'h0000_0013);
        accept();
        respond(32'h0000_0013);
        total++;
        if (bus.io_pc !== 32'hFFFF_FFFC)
            $display("FAIL top_pc: got %h expected %h", bus.io_pc, 32'hFFFF_FFFC);
        else passed++;
        bus.io_instReady = 1'b1;
        step();
        bus.io_instReady = 1'b0;
        total++;
        if ({bus.io_imemReqValid, bus.io_imemAddr} !== {1'b1, 32'h0})
            $display("FAIL pc_wrap: got %h expected %h", {bus.io_imemReqValid, bus.io_imemAddr},
                     {1'b1, 32'h0});
        else passed++;
    endtask

    task automatic test_reset_mid();
        set_redirect(1'b1, 2'b10, 1'b0, 32'h700);
        accept();
        set_redirect(1'b0, 2'b00, 1'b0, 32'h0);
        reset = 1'b0;
        #1;
        total++;
        if ({bus.io_imemReqValid, bus.io_instValid, bus.io_imemAddr} !== {1'b0, 1'b0, 32'h0})
            $display("FAIL async_reset: got %h expected %h",
                     {bus.io_imemReqValid, bus.io_instValid, bus.io_imemAddr}, {1'b0, 1'b0, 32'h0});
        else passed++;
        step();
        reset = 1'b1;
        respond(32'h0000_0013);
        total++;
        if ({bus.io_instValid, bus.io_imemReqValid, bus.io_imemAddr} !== {1'b0, 1'b1, 32'h100})
            $display("FAIL stale_rsp_after_reset: got %h expected %h",
                     {bus.io_instValid, bus.io_imemReqValid, bus.io_imemAddr}, {1'b0, 1'b1, 32'h100});
        else passed++;
    endtask

    task automatic test_misalign();
        accept();
        respond(32'h0000_0067);
        set_redirect(1'b1, 2'b11, 1'b0, 32'h302);
        step();
        set_redirect(1'b0, 2'b00, 1'b0, 32'h0);
        step();
`ifdef FETCH_MISALIGN_CHECK_EN
        total++;
        if ({bus.io_misaligned, bus.io_imemReqValid, bus.io_instValid} !== 3'b100)
            $display("FAIL misalign_halt: got %b expected 100",
                     {bus.io_misaligned, bus.io_imemReqValid, bus.io_instValid});
        else passed++;
`else
        total++;
        if ({bus.io_misaligned, bus.io_imemReqValid, bus.io_imemAddr} !== {1'b0, 1'b1, 32'h300})
            $display("FAIL misalign_forced: got %h expected %h",
                     {bus.io_misaligned, bus.io_imemReqValid, bus.io_imemAddr}, {1'b0, 1'b1, 32'h300});
        else passed++;
`endif
    endtask

    initial begin
        passed = 0;
        total  = 0;
        reset  = 1'b0;
        bus.io_imemReqReady = 1'b0;
        bus.io_imemRspValid = 1'b0;
        bus.io_imemRspData  = 32'h0;
        bus.io_instReady    = 1'b0;
        set_redirect(1'b0, 2'b00, 1'b0, 32'h0);

        test_reset();
        test_first_fetch();
        test_hold_stall();
        test_req_stall();
        test_redirect_wait();
        test_no_redirect();
        test_jalr_hold();
        test_redirect_req();
        test_wrap();
        test_reset_mid();
        test_misalign();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
